hazard_control: RTL
===================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter: MULDIV_LAT, default 4, total stall cycles of a multiply/divide op (legal range 2..15).
REQ-002 Parameter: REG_AW, default 4, register-address width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs_addr, id_rt_addr  input  REG_AW  source registers of the instruction in ID.
REQ-006 ex_mem_read  input  1  instruction in EX is a load.
REQ-007 ex_rd_addr  input  REG_AW  destination register of the instruction in EX.
REQ-008 branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 muldiv_start  input  1  EX holds a multi-cycle multiply/divide this cycle.
REQ-010 halt  input  1  halt/exception raised this cycle.
REQ-011 pc_hold, ifid_hold, idex_hold, exmem_hold  output  1 each  hold controls for the PC and stage buffers.
REQ-012 ifid_flush, idex_flush, exmem_flush  output  1 each  flush (bubble-insert) controls for the stage buffers.
REQ-013 busy  output  1  high in MULDIV or HALT state.
REQ-014 stall_count  output  8  saturating count of cycles with pc_hold high.

Function
REQ-015 FSM states: RUN, MULDIV, HALT; 4-bit down-counter cnt.
REQ-016 Event priority in RUN, highest first: halt, muldiv_start, branch_taken, load-use.
REQ-017 Load-use = ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs_addr || ex_rd_addr==id_rt_addr); in RUN it asserts pc_hold, ifid_hold, idex_flush for that cycle only (combinational, no state change).
REQ-018 branch_taken in RUN asserts ifid_flush and idex_flush for that cycle; no holds.
REQ-019 muldiv_start in RUN: same cycle asserts pc_hold, ifid_hold, idex_hold, exmem_flush; next state MULDIV, cnt <= MULDIV_LAT-1.
REQ-020 MULDIV: asserts pc_hold, ifid_hold, idex_hold, exmem_flush; cnt decrements each cycle; when cnt==1 next state RUN.
REQ-021 Total stall per muldiv op is exactly MULDIV_LAT cycles including the start cycle.
REQ-022 In MULDIV, branch_taken, muldiv_start and load-use are ignored.
REQ-023 halt in RUN or MULDIV: next state HALT; same cycle asserts all four holds and all three flushes.
REQ-024 HALT: all holds high, all flushes low; exits only via reset.
REQ-025 Holds and flushes are never both asserted on the same buffer, except in the halt-entry cycle.
REQ-026 stall_count increments on each cycle with pc_hold high; saturates at 8'hFF.
REQ-027 All outputs other than stall_count and busy are combinational from state, cnt and inputs.

Reset
REQ-028 When reset is high at a rising edge: state <= RUN, cnt <= 0, stall_count <= 0.
REQ-029 While reset is high, all hold and flush outputs are 0 and inputs are ignored.
REQ-030 Reset during MULDIV or HALT aborts the operation; outputs are released the cycle after the reset edge.

Structure
REQ-031 A shared header pipe_defs.vh defines the state encodings (RUN=2'd0, MULDIV=2'd1, HALT=2'd2), MULDIV_LAT and REG_AW defaults.
REQ-032 One sub-module, stall_timer, holds cnt with its load, decrement and terminal (cnt==1) flag; FSM and output decode stay in hazard_control.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd_addr=3, id_rs_addr=3 for one cycle -> pc_hold=ifid_hold=idex_flush=1 that cycle only; stall_count=1. Repeat with ex_rd_addr=0 -> no stall.
REQ-034 Muldiv: muldiv_start pulse with MULDIV_LAT=4 -> pc_hold high for exactly 4 cycles, busy high for 3, exmem_flush high for 4, then all low; stall_count=4.
REQ-035 Branch: branch_taken=1 with a concurrent load-use -> ifid_flush=idex_flush=1, pc_hold=0.
REQ-036 Halt in MULDIV (second busy cycle) -> all holds high from that cycle, busy stays 1 indefinitely; muldiv_start ignored.
REQ-037 Reset mid-op: reset=1 during MULDIV -> after edge state RUN, outputs 0, stall_count=0; a later muldiv_start stalls a full 4 cycles.
REQ-038 Saturation: 300 consecutive stall cycles -> stall_count=8'hFF and holds there.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// default parameters and the bundled hold/flush control word.
package hazard_control_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam int MULDIV_LAT_DEF = 4;
  localparam int REG_AW_DEF     = 4;
  localparam int CNT_W          = 4;
  localparam int SC_W           = 8;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE     = 7'b000_0000;
  localparam ctrl_t CTRL_LOAD_USE = 7'b110_0010;
  localparam ctrl_t CTRL_BRANCH   = 7'b000_0110;
  localparam ctrl_t CTRL_MULDIV   = 7'b111_0001;
  localparam ctrl_t CTRL_HALT_IN  = 7'b111_1111;
  localparam ctrl_t CTRL_HALTED   = 7'b111_1000;

endpackage

// File: rtl/hazard_control_stall_timer.sv
// Multi-cycle stall timer: loads MULDIV_LAT-1 on op start, counts down while
// the op is in flight, and flags the last stall cycle (cnt == 1).
module stall_timer
  import hazard_control_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(MULDIV_LAT - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_terminal = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use, branch, multi-cycle mul/div and halt
// handling with per-stage hold/flush outputs and a saturating stall counter.
//   state  | meaning
//   RUN    | normal issue; load-use and branch handled combinationally
//   MULDIV | front end frozen while the mul/div completes
//   HALT   | everything held until reset
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_id_rs_addr,
  input  logic [REG_AW-1:0] i_id_rt_addr,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_branch_taken,
  input  logic              i_muldiv_start,
  input  logic              i_halt,
  output logic              o_pc_hold,
  output logic              o_ifid_hold,
  output logic              o_idex_hold,
  output logic              o_exmem_hold,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_exmem_flush,
  output logic              o_busy,
  output logic [SC_W-1:0]   o_stall_count
);

  state_e           r_state;
  state_e           w_next;
  ctrl_t            w_ctrl;
  logic [SC_W-1:0]  r_stall_count;
  logic [CNT_W-1:0] w_cnt;
  logic             w_terminal;
  logic             w_load_use;
  logic             w_timer_load;

  assign w_load_use = i_ex_mem_read && (i_ex_rd_addr != '0) &&
                      ((i_ex_rd_addr == i_id_rs_addr) || (i_ex_rd_addr == i_id_rt_addr));
  assign w_timer_load = (r_state == ST_RUN) && !i_halt && i_muldiv_start;

  stall_timer #(.MULDIV_LAT(MULDIV_LAT)) u_stall_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_timer_load),
    .i_dec      (r_state == ST_MULDIV),
    .o_cnt      (w_cnt),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_halt)              w_next = ST_HALT;
        else if (i_muldiv_start) w_next = ST_MULDIV;
      end
      ST_MULDIV: begin
        if (i_halt)          w_next = ST_HALT;
        else if (w_terminal) w_next = ST_RUN;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RUN;
    endcase
  end

  // Reset masks every hold/flush so a stuck pipeline is released immediately.
  always_comb begin
    w_ctrl = CTRL_NONE;
    if (!i_reset) begin
      case (r_state)
        ST_RUN: begin
          if (i_halt)              w_ctrl = CTRL_HALT_IN;
          else if (i_muldiv_start) w_ctrl = CTRL_MULDIV;
          else if (i_branch_taken) w_ctrl = CTRL_BRANCH;
          else if (w_load_use)     w_ctrl = CTRL_LOAD_USE;
        end
        ST_MULDIV: w_ctrl = i_halt ? CTRL_HALT_IN : CTRL_MULDIV;
        ST_HALT:   w_ctrl = CTRL_HALTED;
        default:   w_ctrl = CTRL_NONE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (w_ctrl.pc_hold && (r_stall_count != {SC_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_pc_hold     = w_ctrl.pc_hold;
  assign o_ifid_hold   = w_ctrl.ifid_hold;
  assign o_idex_hold   = w_ctrl.idex_hold;
  assign o_exmem_hold  = w_ctrl.exmem_hold;
  assign o_ifid_flush  = w_ctrl.ifid_flush;
  assign o_idex_flush  = w_ctrl.idex_flush;
  assign o_exmem_flush = w_ctrl.exmem_flush;
  assign o_busy        = (r_state != ST_RUN);
  assign o_stall_count = r_stall_count;

endmodule
